// File: rtl/dev_timer.sv
// dev_timer: memory-mapped countdown timer on the CPU device bus.
// Registers: CTRL (EN, MODE, IM), PRESET and COUNT.
// A four-state FSM sequences the preset load, the countdown and the interrupt.
// CPU writes take priority over the FSM's own updates to CTRL and irq_flag.
module dev_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_ctrl;
    logic [3:0]       w_ctrl_next;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] w_preset_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             r_irq_flag;
    logic             w_irq_flag_next;

    logic             w_en;
    logic             w_auto;
    logic             w_im;

    // CTRL field decode; MODE values 2 and 3 fall back to one-shot.
    assign w_en   = r_ctrl[0];
    assign w_auto = (r_ctrl[2:1] == 2'b01);
    assign w_im   = r_ctrl[3];

    // Register update; reset restores every register and drops any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= 4'd0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ctrl     <= w_ctrl_next;
            r_preset   <= w_preset_next;
            r_count    <= w_count_next;
            r_irq_flag <= w_irq_flag_next;
        end
    end

    // Next-state logic: FSM first, then CPU writes override CTRL/PRESET/irq_flag.
    always_comb begin
        w_state_next    = r_state;
        w_ctrl_next     = r_ctrl;
        w_preset_next   = r_preset;
        w_count_next    = r_count;
        w_irq_flag_next = r_irq_flag;

        case (r_state)
            S_IDLE: begin
                if (w_en) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_en) begin
                    w_count_next = r_preset;
                    w_state_next = S_CNT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CNT: begin
                if (!w_en) begin
                    w_state_next = S_IDLE;
                end else if (r_count == '0) begin
                    w_state_next    = S_INT;
                    w_irq_flag_next = 1'b1;
                end else begin
                    w_count_next = r_count - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            S_INT: begin
                if (w_auto) begin
                    // Auto-reload: one-cycle irq pulse, then reload.
                    w_irq_flag_next = 1'b0;
                    w_state_next    = S_LOAD;
                end else begin
                    // One-shot: stop the timer, leave irq_flag latched.
                    w_ctrl_next[0] = 1'b0;
                    w_state_next   = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // CPU writes land last so they win over the FSM's CTRL/irq_flag updates.
        if (we) begin
            if (addr == A_CTRL) begin
                w_ctrl_next     = wd[3:0];
                w_irq_flag_next = 1'b0;
            end else if (addr == A_PRESET) begin
                w_preset_next   = wd;
                w_irq_flag_next = 1'b0;
            end
        end
    end

    // Combinational read mux from current register state.
    always_comb begin
        rd = '0;
        case (addr)
            A_CTRL:   rd = {{(WIDTH-4){1'b0}}, r_ctrl};
            A_PRESET: rd = r_preset;
            A_COUNT:  rd = r_count;
            default:  rd = '0;
        endcase
    end

    assign irq = r_irq_flag & w_im;

endmodule

// File: tb/tb_dev_timer.sv
// tb_dev_timer: directed-sequence bench for dev_timer with immediate assertions.
module tb_dev_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    int n_checks;
    int n_fail;

    dev_timer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-24s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rd, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // Single-cycle bus write; returns 1 unit after the edge that applied it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        wd   = d;
        tick();
        we   = 1'b0;
    endtask

    logic [31:0] cnt_tail [0:8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        addr     = 2'd0;
        we       = 1'b0;
        wd       = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd_chk("rst_ctrl",   2'd0, 32'h0);
        rd_chk("rst_preset", 2'd1, 32'h0);
        rd_chk("rst_count",  2'd2, 32'h0);
        rd_chk("rst_rsvd",   2'd3, 32'h0);
        irq_chk("rst_irq", 1'b0);

        // One-shot, PRESET=3, IM=1: count 3..0 after E2..E5, irq after E6
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);                       // E0
        tick();                                // E1
        for (int i = 2; i <= 5; i++) begin
            tick();
            rd_chk($sformatf("os_count_E%0d", i), 2'd2, 32'(5 - i));
            irq_chk($sformatf("os_irq_E%0d", i), 1'b0);
        end
        tick();                                // E6
        irq_chk("os_irq_E6", 1'b1);
        tick();                                // E7
        rd_chk("os_ctrl_E7", 2'd0, 32'h8);
        irq_chk("os_irq_E7", 1'b1);
        tick();
        tick();
        irq_chk("os_irq_held", 1'b1);
        wr(2'd0, 32'h8);
        irq_chk("os_irq_cleared", 1'b0);

        // Auto-reload, PRESET=2: irq one cycle every 5 cycles
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);                       // E0
        for (int i = 1; i <= 20; i++) begin
            int ph;
            logic [31:0] ec;
            tick();
            ph = (i - 2) % 5;
            if (i < 2)        ec = 32'd0;
            else if (ph == 0) ec = 32'd2;
            else if (ph == 1) ec = 32'd1;
            else              ec = 32'd0;
            irq_chk($sformatf("ar_irq_E%0d", i), (i >= 5) && ((i - 5) % 5 == 0));
            rd_chk($sformatf("ar_count_E%0d", i), 2'd2, ec);
        end
        tick();                                // E21
        tick();                                // E22
        rd_chk("ar_count_E22", 2'd2, 32'd2);
        wr(2'd1, 32'd4);                       // E23: new preset used at next LOAD
        cnt_tail = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        for (int i = 24; i <= 32; i++) begin
            tick();
            irq_chk($sformatf("ar2_irq_E%0d", i), (i == 25) || (i == 32));
            rd_chk($sformatf("ar2_count_E%0d", i), 2'd2, cnt_tail[i - 24]);
        end
        wr(2'd0, 32'h0);
        tick();
        tick();

        // Freeze mid-count, then re-enable reloads from preset
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);                       // E0
        for (int i = 1; i <= 5; i++) tick();   // E5: count 7
        rd_chk("fz_count_E5", 2'd2, 32'd7);
        wr(2'd0, 32'h8);                       // E6: count 6, EN cleared
        rd_chk("fz_count_E6", 2'd2, 32'd6);
        tick();
        tick();
        tick();
        rd_chk("fz_count_held", 2'd2, 32'd6);
        rd_chk("fz_ctrl", 2'd0, 32'h8);
        wr(2'd0, 32'h9);                       // F0
        tick();                                // F1
        rd_chk("fz_count_F1", 2'd2, 32'd6);
        tick();                                // F2
        rd_chk("fz_count_F2", 2'd2, 32'd10);
        wr(2'd0, 32'h0);
        tick();
        tick();

        // PRESET=0, IM=0: irq never asserts; CTRL write clears flag
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);                       // E0
        for (int i = 1; i <= 5; i++) begin
            tick();
            irq_chk($sformatf("z_irq_E%0d", i), 1'b0);
        end
        rd_chk("z_ctrl_en_cleared", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        irq_chk("z_irq_after_im", 1'b0);
        tick();
        irq_chk("z_irq_later", 1'b0);
        wr(2'd0, 32'h0);

        // Reset during CNT with count=5 and a simultaneous PRESET write
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);                       // E0
        for (int i = 1; i <= 5; i++) tick();   // E5: count 5
        rd_chk("rs_count_pre", 2'd2, 32'd5);
        reset = 1'b1;
        we    = 1'b1;
        addr  = 2'd1;
        wd    = 32'h55;
        tick();
        reset = 1'b0;
        we    = 1'b0;
        rd_chk("rs_ctrl",   2'd0, 32'h0);
        rd_chk("rs_preset", 2'd1, 32'h0);
        rd_chk("rs_count",  2'd2, 32'h0);
        rd_chk("rs_rsvd",   2'd3, 32'h0);
        irq_chk("rs_irq", 1'b0);
        tick();
        rd_chk("rs_count_idle", 2'd2, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
